// File: rtl/err_code_pkg.sv
// Shared types for the error event logger: error codes, opcodes, the logged
// event record and the burst FSM states.
// Optional feature macro: ERR_LOG_TIMESTAMP_EN. When it is defined, each event
// record carries a 16-bit capture timestamp.
package err_code_pkg;

    typedef enum logic [3:0] {
        NONE         = 4'h0,
        DIVIDE_ZERO  = 4'h1,
        OVERFLOW     = 4'h2,
        UNDERFLOW    = 4'h3,
        INVALID_OP   = 4'h4,
        OUT_OF_RANGE = 4'h5,
        TIMEOUT      = 4'h6,
        UNKNOWN      = 4'hF
    } error_code_e;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_SQRT = 3'd5;

    // One logged event. Codes outside the enum (7..E) are stored unchanged.
    typedef struct packed {
        error_code_e code;
        logic [2:0]  operation;
        logic [7:0]  result;
`ifdef ERR_LOG_TIMESTAMP_EN
        logic [15:0] timestamp;
`endif
    } err_event_t;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        STREAK  = 2'd1,
        ALARM   = 2'd2
    } burst_state_e;

endpackage

// File: rtl/err_event_fifo.sv
// First-word-fall-through FIFO of err_event_t records.
// Pointers are one bit wider than the address so full and empty can be told
// apart when the address bits match. The head is presented combinationally
// and forced to zero while the FIFO is empty.
// Optional feature macro: ERR_LOG_TIMESTAMP_EN (changes the record width only).
module err_event_fifo
    import err_code_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  err_event_t             wr_data,
    output err_event_t             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    err_event_t    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          push_ok;
    logic          pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A push into a full FIFO is only accepted when a pop frees the slot
    // in the same cycle; popping an empty FIFO is ignored.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Storage write; no reset so the array can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/error_event_logger.sv
// Error event logger: captures every failing result into an FWFT event FIFO,
// keeps 16 saturating per-code counters, and raises a sticky alarm when one
// non-zero code repeats BURST_LEN times in a row (idle cycles do not break a
// streak).
// Optional feature macro: ERR_LOG_TIMESTAMP_EN. Defined: a free-running 16-bit
// cycle counter is stored with each event. Undefined: no counter, no storage,
// rd_timestamp is tied to 0.
module error_event_logger
    import err_code_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [2:0]                  in_operation,
    input  logic [3:0]                  in_error_code,
    input  logic [7:0]                  in_result,
    input  logic                        rd_en,
    output logic                        rd_valid,
    output logic [3:0]                  rd_error_code,
    output logic [2:0]                  rd_operation,
    output logic [7:0]                  rd_result,
    output logic [15:0]                 rd_timestamp,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic [3:0]                  cnt_sel,
    output logic [CNT_WIDTH-1:0]        cnt_value,
    input  logic                        clear,
    output logic                        alarm
);

    localparam int SW = $clog2(BURST_LEN + 1);

    logic                  push_req;
    logic                  pop_req;
    logic                  fifo_full;
    logic                  fifo_empty;
    err_event_t            wr_event;
    err_event_t            head_event;

    logic                  overflow_q;
    logic [CNT_WIDTH-1:0]  cnt_value_q;
    logic [15:0][CNT_WIDTH-1:0] cnt_q;
    logic [15:0][CNT_WIDTH-1:0] cnt_d;

    burst_state_e          state_q;
    logic [3:0]            streak_code_q;
    logic [SW-1:0]         streak_cnt_q;
    logic                  alarm_q;

    assign push_req = in_valid && (in_error_code != 4'd0);
    assign pop_req  = rd_en && !fifo_empty;

`ifdef ERR_LOG_TIMESTAMP_EN
    logic [15:0] timestamp_q;

    // Free-running capture clock; wraps naturally and ignores clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            timestamp_q <= '0;
        end else begin
            timestamp_q <= timestamp_q + 16'd1;
        end
    end
`endif

    // Assemble the record written into the FIFO.
    always_comb begin
        wr_event           = '0;
        wr_event.code      = error_code_e'(in_error_code);
        wr_event.operation = in_operation;
        wr_event.result    = in_result;
`ifdef ERR_LOG_TIMESTAMP_EN
        wr_event.timestamp = timestamp_q;
`endif
    end

    err_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_req),
        .pop     (pop_req),
        .wr_data (wr_event),
        .rd_data (head_event),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rd_valid      = !fifo_empty;
    assign rd_error_code = head_event.code;
    assign rd_operation  = head_event.operation;
    assign rd_result     = head_event.result;
`ifdef ERR_LOG_TIMESTAMP_EN
    assign rd_timestamp  = head_event.timestamp;
`else
    assign rd_timestamp  = 16'h0000;
`endif

    // Sticky drop flag: full, pushing, and nothing leaving this cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            overflow_q <= 1'b0;
        end else if (push_req && fifo_full && !pop_req) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

    // Per-code next value: clear wins, otherwise saturating increment.
    for (genvar gi = 0; gi < 16; gi++) begin : g_cnt
        assign cnt_d[gi] = clear ? '0 :
                           (in_valid && (in_error_code == 4'(gi)) && (cnt_q[gi] != '1))
                               ? cnt_q[gi] + 1'b1 : cnt_q[gi];
    end

    // Counter bank register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Registered counter read port, one cycle behind cnt_sel.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_value_q <= '0;
        end else begin
            cnt_value_q <= cnt_q[cnt_sel];
        end
    end

    assign cnt_value = cnt_value_q;

    // Burst detector with registered alarm output.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q       <= MONITOR;
            streak_code_q <= '0;
            streak_cnt_q  <= '0;
            alarm_q       <= 1'b0;
        end else begin
            case (state_q)
                MONITOR: begin
                    if (in_valid && in_error_code != 4'd0) begin
                        state_q       <= STREAK;
                        streak_code_q <= in_error_code;
                        streak_cnt_q  <= SW'(1);
                    end
                end
                STREAK: begin
                    if (in_valid) begin
                        if (in_error_code == 4'd0) begin
                            state_q      <= MONITOR;
                            streak_cnt_q <= '0;
                        end else if (in_error_code == streak_code_q) begin
                            streak_cnt_q <= streak_cnt_q + 1'b1;
                            if ((streak_cnt_q + 1'b1) == SW'(BURST_LEN)) begin
                                state_q <= ALARM;
                                alarm_q <= 1'b1;
                            end
                        end else begin
                            streak_code_q <= in_error_code;
                            streak_cnt_q  <= SW'(1);
                        end
                    end
                end
                ALARM: begin
                    alarm_q <= 1'b1;
                end
                default: begin
                    state_q <= MONITOR;
                end
            endcase
        end
    end

    assign alarm = alarm_q;

endmodule
